// File: rtl/inv_edge_counter_pkg.sv
// Shared types and defaults for the inverter edge counter and related cell-monitor stages.
package inv_edge_counter_pkg;

  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefGateCycles = 1024;
  localparam int unsigned DefTimerW     = 24;

  typedef enum logic {
    StIdle = 1'b0,
    StGate = 1'b1
  } state_e;

  // A single-byte result still gets a 1-bit selector so the port never collapses to zero width.
  function automatic int unsigned byte_sel_w(input int unsigned cnt_w);
    return (cnt_w / 8 > 1) ? $clog2(cnt_w / 8) : 1;
  endfunction

endpackage

// File: rtl/inv_edge_counter_sync.sv
// Brings an asynchronous analog-cell output into the clk domain and flags its rising edges.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/inv_edge_counter.sv
// Counts rising edges of the inverter output over a fixed gate window and exposes the
// latched, saturating count one byte at a time.
module inv_edge_counter
  import inv_edge_counter_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned GATE_CYCLES = DefGateCycles,
  parameter int unsigned TIMER_W     = DefTimerW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          sig_in,
  input  logic                          start,
  input  logic [byte_sel_w(CNT_W)-1:0]  byte_sel,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf,
  output logic [7:0]                    data_out
);

  localparam int unsigned NumBytes = CNT_W / 8;
  localparam int unsigned SelW     = byte_sel_w(CNT_W);
  localparam logic [CNT_W-1:0]   CntMax    = '1;
  localparam logic [TIMER_W-1:0] TimerLoad = TIMER_W'(GATE_CYCLES - 1);

  logic rise;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .rise  (rise)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]   result_q, result_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [7:0]         data_q, data_d;

  assign cnt_inc = (rise && (cnt_q != CntMax)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    ovf_pend_d = ovf_pend_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    if (!ena) begin
      // Abort: drop the partial count, keep the last published result.
      state_d    = StIdle;
      cnt_d      = '0;
      ovf_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StGate;
            cnt_d      = '0;
            timer_d    = TimerLoad;
            ovf_pend_d = 1'b0;
          end
        end
        StGate: begin
          cnt_d      = cnt_inc;
          ovf_pend_d = ovf_pend_q | (cnt_inc == CntMax);
          if (timer_q == '0) begin
            // Terminal cycle: its own rise is folded into the published result.
            state_d  = StIdle;
            result_d = cnt_inc;
            ovf_d    = ovf_pend_d;
            done_d   = 1'b1;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    data_d = 8'h00;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (byte_sel == SelW'(i)) data_d = result_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      timer_q    <= '0;
      ovf_pend_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      ovf_pend_q <= ovf_pend_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  assign busy     = (state_q == StGate);
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_inv_edge_counter.sv
// Bench for inv_edge_counter: 16-bit and 8-bit instances share stimulus and are checked against
// a window-count model built from the sampled history of sig_in.
module tb_inv_edge_counter;

  localparam int unsigned G = 1024;

  logic       clk = 1'b0;
  logic       rst_n, ena, sig_in, start;
  logic [0:0] byte_sel;
  logic       busy16, done16, ovf16, busy8, done8, ovf8;
  logic [7:0] data16, data8;

  inv_edge_counter #(.CNT_W(16), .GATE_CYCLES(G), .TIMER_W(24)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .start(start),
    .byte_sel(byte_sel), .busy(busy16), .done(done16), .ovf(ovf16), .data_out(data16)
  );

  inv_edge_counter #(.CNT_W(8), .GATE_CYCLES(G), .TIMER_W(24)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .start(start),
    .byte_sel(byte_sel), .busy(busy8), .done(done8), .ovf(ovf8), .data_out(data8)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sig_period = 2;  // >0 square wave period, 0 hold sig_level, <0 random bits
  bit sig_level  = 1'b0;
  bit samp[$];         // sig_in as seen at each out-of-reset posedge
  int last_n = 0;

  always @(posedge clk) if (rst_n) samp.push_back(sig_in);

  initial begin : sig_drv
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      ph++;
      if (sig_period > 0)      sig_in = ((ph % sig_period) < (sig_period / 2));
      else if (sig_period < 0) sig_in = 1'($urandom_range(0, 1));
      else                     sig_in = sig_level;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit samp_at(input int i);
    return (i >= 0 && i < samp.size()) ? samp[i] : 1'b0;
  endfunction

  // Rising edges of sig_in that reach the counter at posedges t0+1 .. t0+G.
  function automatic int window_count(input int t0);
    int n;
    n = 0;
    for (int e = t0 + 1; e <= t0 + int'(G); e++) begin
      if (samp_at(e - 2) && !samp_at(e - 3)) n++;
    end
    return n;
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy16"}, 32'(busy16), 32'd0);
    check_eq({tag, "_done16"}, 32'(done16), 32'd0);
    check_eq({tag, "_ovf16"},  32'(ovf16),  32'd0);
    check_eq({tag, "_data16"}, 32'(data16), 32'd0);
    check_eq({tag, "_busy8"},  32'(busy8),  32'd0);
    check_eq({tag, "_done8"},  32'(done8),  32'd0);
    check_eq({tag, "_ovf8"},   32'(ovf8),   32'd0);
    check_eq({tag, "_data8"},  32'(data8),  32'd0);
  endtask

  // Expects start=1 already driven for the coming posedge.
  task automatic gate_window(input string tag, input int extra_k, input bit chain);
    int t0, n, e16, e8;
    bit bad_busy, bad_done;
    t0 = samp.size();
    bad_busy = 1'b0;
    bad_done = 1'b0;
    step();
    start = 1'b0;
    if (!(busy16 && busy8)) bad_busy = 1'b1;
    if (done16 || done8) bad_done = 1'b1;
    for (int k = 1; k <= int'(G); k++) begin
      step();
      start = 1'b0;
      if (k < int'(G)) begin
        if (!(busy16 && busy8)) bad_busy = 1'b1;
        if (done16 || done8) bad_done = 1'b1;
      end else begin
        if (busy16 || busy8) bad_busy = 1'b1;
        if (!(done16 && done8)) bad_done = 1'b1;
      end
      if (k == extra_k) start = 1'b1;
      if (k == int'(G) && chain) start = 1'b1;
    end
    check_eq({tag, "_busy_window"}, 32'(bad_busy), 32'd0);
    check_eq({tag, "_done_timing"}, 32'(bad_done), 32'd0);
    n   = window_count(t0);
    e16 = (n > 65535) ? 65535 : n;
    e8  = (n > 255) ? 255 : n;
    last_n = n;
    check_eq({tag, "_ovf16"}, 32'(ovf16), 32'(n >= 65535));
    check_eq({tag, "_ovf8"},  32'(ovf8),  32'(n >= 255));
    if (!chain) begin
      byte_sel = 1'b0;
      step();
      check_eq({tag, "_done_once"}, 32'(done16 | done8), 32'd0);
      check_eq({tag, "_d16_b0"}, 32'(data16), 32'(e16 & 8'hff));
      check_eq({tag, "_d8_b0"},  32'(data8),  32'(e8));
      byte_sel = 1'b1;
      step();
      check_eq({tag, "_d16_b1"}, 32'(data16), 32'((e16 >> 8) & 8'hff));
      check_eq({tag, "_d8_b1"},  32'(data8),  32'd0);
    end
  endtask

  initial begin : main
    bit saw;
    int p16, p8;
    rst_n = 1'b0;
    ena = 1'b0;
    start = 1'b0;
    byte_sel = 1'b0;
    sig_period = 2;

    // Reset held with sig_in toggling.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_zero("reset");
      step();
    end
    rst_n = 1'b1;
    samp.delete();
    ena = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done16 || done8 || busy16 || busy8) saw = 1'b1;
    end
    check_eq("idle_no_activity", 32'(saw), 32'd0);

    // Known rate, then an ignored mid-window start, then a start in the done cycle.
    sig_period = 8;
    start = 1'b1;
    gate_window("rate8", -1, 1'b0);
    start = 1'b1;
    gate_window("restart_ign", 10, 1'b1);
    sig_period = -1;
    gate_window("chained", -1, 1'b0);

    // Saturation of the 8-bit instance, then a quiet window clears ovf.
    sig_period = 2;
    start = 1'b1;
    gate_window("sat", -1, 1'b0);
    sig_period = 0;
    sig_level = 1'b0;
    start = 1'b1;
    gate_window("quiet", -1, 1'b0);

    // Abort after a run whose result is 64.
    sig_period = 16;
    start = 1'b1;
    gate_window("rate16", -1, 1'b0);
    p16 = (last_n > 65535) ? 65535 : last_n;
    p8  = (last_n > 255) ? 255 : last_n;
    byte_sel = 1'b0;
    sig_period = 8;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 499; i++) step();
    ena = 1'b0;
    step();
    check_eq("abort_busy16", 32'(busy16), 32'd0);
    check_eq("abort_busy8",  32'(busy8),  32'd0);
    saw = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 5) ena = 1'b1;
      step();
      if (done16 || done8 || busy16 || busy8) saw = 1'b1;
    end
    check_eq("abort_no_done", 32'(saw), 32'd0);
    check_eq("abort_d16", 32'(data16), 32'(p16 & 8'hff));
    check_eq("abort_d8",  32'(data8),  32'(p8));
    check_eq("abort_ovf8", 32'(ovf8), 32'(last_n >= 255));

    // Asynchronous reset in the middle of a window.
    sig_period = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 299; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    samp.delete();
    start = 1'b1;
    gate_window("post_rst", -1, 1'b0);

    // Randomized windows.
    for (int r = 0; r < 4; r++) begin
      case ($urandom_range(0, 2))
        0: sig_period = int'($urandom_range(2, 40));
        1: sig_period = -1;
        default: begin
          sig_period = 0;
          sig_level = 1'($urandom_range(0, 1));
        end
      endcase
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) step();
      start = 1'b1;
      gate_window($sformatf("rand%0d", r), -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
